mix_columns_seq: RTL and testbench

MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

---
 rtl/mix_columns_seq.sv | 112 +++++++++++
 tb/tb_mix_columns_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mix_columns_seq.sv
// AES MixColumns over a 128-bit state, one column per clock through a single
// shared 4-byte column datapath; valid/ready handshakes on input and output.
module mix_columns_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high; in_ready is high only in IDLE, out_valid only in DONE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COL  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e       fsm_q, fsm_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] in_q, in_d;
    logic [127:0] out_q, out_d;

    logic [31:0]  col_word;
    logic [31:0]  col_res;
    logic [7:0]   a [4];
    logic [7:0]   x2 [4];
    logic [7:0]   x3 [4];

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    always_comb begin
        col_word = in_q[127:96];
        case (col_q)
            2'd0: col_word = in_q[127:96];
            2'd1: col_word = in_q[95:64];
            2'd2: col_word = in_q[63:32];
            2'd3: col_word = in_q[31:0];
            default: col_word = in_q[127:96];
        endcase
    end

    // The one column datapath: row 0 sits in the most significant byte.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            a[r]  = col_word[31-8*r -: 8];
            x2[r] = xtime(a[r]);
            x3[r] = x2[r] ^ a[r];
        end
        col_res[31:24] = x2[0] ^ x3[1] ^ a[2]  ^ a[3];
        col_res[23:16] = a[0]  ^ x2[1] ^ x3[2] ^ a[3];
        col_res[15:8]  = a[0]  ^ a[1]  ^ x2[2] ^ x3[3];
        col_res[7:0]   = x3[0] ^ a[1]  ^ a[2]  ^ x2[3];
    end

    always_comb begin
        fsm_d = fsm_q;
        col_d = col_q;
        in_d  = in_q;
        out_d = out_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    in_d  = state_in;
                    col_d = 2'd0;
                    fsm_d = COL;
                end
            end
            COL: begin
                case (col_q)
                    2'd0: out_d[127:96] = col_res;
                    2'd1: out_d[95:64]  = col_res;
                    2'd2: out_d[63:32]  = col_res;
                    2'd3: out_d[31:0]   = col_res;
                    default: out_d[127:96] = col_res;
                endcase
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) fsm_d = DONE;
            end
            DONE: begin
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= IDLE;
            col_q <= 2'd0;
            in_q  <= 128'h0;
            out_q <= 128'h0;
        end else begin
            fsm_q <= fsm_d;
            col_q <= col_d;
            in_q  <= in_d;
            out_q <= out_d;
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q != IDLE);
    assign state_out = out_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: reset, FIPS-197 vector, backpressure,
// busy-ignore, mid-block reset and column ordering.
module tb_mix_columns_seq;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    int checks_q = 0;
    int errors_q = 0;

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] B2_IN    = 128'hdb135345f20a225c01010101c6c6c6c6;
    localparam logic [127:0] B2_OUT   = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
    localparam logic [127:0] C0_IN    = 128'h80000000000000000000000000000000;
    // b0 = 2*80 = 1b, b1 = b2 = 80, b3 = 3*80 = 9b
    localparam logic [127:0] C0_OUT   = 128'h1b80809b000000000000000000000000;

    mix_columns_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks_q++;
        if (act !== exp) begin
            errors_q++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Present one block at a negedge; returns at the negedge after the accept edge.
    task automatic accept(input logic [127:0] din, input string tag);
        check({tag, "_in_ready_pre"}, 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        state_in = din;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_busy"}, 128'(busy), 128'd1);
        check({tag, "_in_ready_busy"}, 128'(in_ready), 128'd0);
    endtask

    // Waits for out_valid; 'start' is the number of edges already elapsed since accept.
    task automatic wait_out(input logic [127:0] exp, input string tag, input int start);
        int lat;
        lat = 0;
        for (int n = start + 1; n <= 20; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        check({tag, "_latency"}, 128'(lat), 128'd4);
        check({tag, "_result"}, state_out, exp);
    endtask

    initial begin
        int bad;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        state_in  = 128'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_state_out", state_out, 128'h0);

        // FIPS vector, output consumed immediately
        accept(FIPS_IN, "fips");
        wait_out(FIPS_OUT, "fips", 0);
        @(negedge clk);
        check("fips_valid_1cyc", 128'(out_valid), 128'd0);
        check("fips_in_ready_after", 128'(in_ready), 128'd1);

        // Backpressure
        out_ready = 1'b0;
        accept(FIPS_IN, "bp");
        wait_out(FIPS_OUT, "bp", 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 128'(out_valid), 128'd1);
            check("bp_hold_data", state_out, FIPS_OUT);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_idle", 128'(in_ready), 128'd1);
        check("bp_release_valid", 128'(out_valid), 128'd0);

        // Busy-ignore: second block offered while the first is in flight
        accept(FIPS_IN, "ign");
        @(negedge clk);
        in_valid = 1'b1;
        state_in = B2_IN;
        check("ign_in_ready", 128'(in_ready), 128'd0);
        wait_out(FIPS_OUT, "ign", 1);
        @(negedge clk);
        check("ign_idle_ready", 128'(in_ready), 128'd1);
        check("ign_idle_valid", 128'(out_valid), 128'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2_busy", 128'(busy), 128'd1);
        wait_out(B2_OUT, "b2", 0);
        @(negedge clk);

        // Reset during the second COL cycle
        accept(FIPS_IN, "mid");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_in_ready", 128'(in_ready), 128'd1);
        check("mid_busy", 128'(busy), 128'd0);
        check("mid_state_out", state_out, 128'h0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) bad++;
            @(negedge clk);
        end
        check("mid_no_valid", 128'(bad), 128'd0);
        accept(FIPS_IN, "mid_fips");
        wait_out(FIPS_OUT, "mid_fips", 0);
        @(negedge clk);

        // Column ordering and xtime reduction
        accept(C0_IN, "col0");
        wait_out(C0_OUT, "col0", 0);
        @(negedge clk);
        check("col0_idle", 128'(in_ready), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks_q, errors_q);
        $finish;
    end

endmodule
